// File: rtl/conv2d_mc.sv
// Multi-channel strided KxK convolution over a raster pixel stream with per-channel
// requantisation (shift, optional ReLU, saturation) and an elastic output stage.
module conv2d_mc #(
  parameter int LineWidthPx = 160,
  parameter int LineCountPx = 120,
  parameter int WidthIn     = 8,
  parameter int WeightWidth = 2,
  parameter int KernelWidth = 3,
  parameter int ChannelsOut = 4,
  parameter int Stride      = 1,
  parameter int Shift       = 0,
  parameter int WidthOut    = 16
) (
  input  logic                                                       clk_i,
  input  logic                                                       rst_ni,
  input  logic                                                       valid_i,
  output logic                                                       ready_o,
  input  logic [WidthIn-1:0]                                         data_i,
  input  logic [ChannelsOut*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
  input  logic                                                       relu_en_i,
  output logic                                                       valid_o,
  input  logic                                                       ready_i,
  output logic [ChannelsOut*WidthOut-1:0]                            data_o,
  output logic                                                       last_o
);
  localparam int K  = KernelWidth;
  localparam int KK = K * K;
  localparam int NW = ChannelsOut * KK * WeightWidth;
  localparam int AW = WidthIn + WeightWidth + $clog2(KK) + 1;
  localparam int SW = (AW > WidthOut) ? AW : WidthOut;
  localparam int XW = $clog2(LineWidthPx);
  localparam int YW = $clog2(LineCountPx);
  localparam int PW = (Stride > 1) ? $clog2(Stride) : 1;
  localparam int XL = K - 1 + Stride * ((LineWidthPx - K) / Stride);
  localparam int YL = K - 1 + Stride * ((LineCountPx - K) / Stride);
  localparam logic signed [SW-1:0] SMAX = {{(SW-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};

  logic [XW-1:0]      r_x, w_x_nxt;
  logic [YW-1:0]      r_y, w_y_nxt;
  logic [PW-1:0]      r_px, r_py, w_px_nxt, w_py_nxt;
  logic               w_fire, w_produce, w_last;
  logic               r_valid, r_last;
  logic [WidthIn-1:0] r_win  [K][K];
  logic [WidthIn-1:0] r_line [K-1][LineWidthPx-1];
  logic [NW-1:0]      r_wts;
  logic               r_relu;
  logic signed [AW-1:0]        w_acc [ChannelsOut];
  logic [ChannelsOut*WidthOut-1:0] w_data;

  function automatic logic signed [AW-1:0] mul(input logic signed [WeightWidth-1:0] w,
                                               input logic [WidthIn-1:0] p);
    logic signed [AW-1:0] wv, pv;
    wv = {{(AW-WeightWidth){w[WeightWidth-1]}}, w};
    pv = {{(AW-WidthIn){1'b0}}, p};
    return wv * pv;
  endfunction

  function automatic logic signed [WidthOut-1:0] sat(input logic signed [SW-1:0] s);
    if (s > SMAX) return SMAX[WidthOut-1:0];
    if (s < SMIN) return SMIN[WidthOut-1:0];
    return s[WidthOut-1:0];
  endfunction

  function automatic logic signed [WidthOut-1:0] requant(input logic signed [AW-1:0] acc,
                                                         input logic relu);
    logic signed [SW-1:0] s;
    s = SW'(acc >>> Shift);
    if (relu && s[SW-1]) s = '0;
    return sat(s);
  endfunction

  assign ready_o   = ~r_valid | ready_i;
  assign w_fire    = valid_i & ready_o;
  assign w_produce = w_fire && (r_x >= XW'(K-1)) && (r_y >= YW'(K-1)) &&
                     (r_px == '0) && (r_py == '0);
  assign w_last    = (r_x == XW'(XL)) && (r_y == YW'(YL));

  // Phase counters hold the stride phase of the pixel about to be accepted;
  // they are re-anchored so column/row K-1 is always phase 0.
  always_comb begin
    w_x_nxt  = r_x + 1'b1;
    w_y_nxt  = r_y;
    w_px_nxt = (r_px == PW'(Stride-1)) ? '0 : r_px + 1'b1;
    w_py_nxt = r_py;
    if (r_x == XW'(LineWidthPx-1)) begin
      w_x_nxt  = '0;
      w_y_nxt  = (r_y == YW'(LineCountPx-1)) ? '0 : r_y + 1'b1;
      w_py_nxt = (r_py == PW'(Stride-1)) ? '0 : r_py + 1'b1;
      if (w_y_nxt == YW'(K-1)) w_py_nxt = '0;
    end
    if (w_x_nxt == XW'(K-1)) w_px_nxt = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x  <= '0;
      r_y  <= '0;
      r_px <= '0;
      r_py <= '0;
    end else if (w_fire) begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_px <= w_px_nxt;
      r_py <= w_py_nxt;
    end
  end

  // Each line delay is fed from the previous cycle's right column, so W-1 taps give a full line.
  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      for (int r = 0; r < K-1; r++) begin
        r_line[r][0] <= r_win[r+1][K-1];
        for (int i = LineWidthPx-2; i > 0; i--) r_line[r][i] <= r_line[r][i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) r_win[r][c] <= '0;
      r_wts  <= '0;
      r_relu <= 1'b0;
    end else if (w_fire) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++) r_win[r][c] <= r_win[r][c+1];
      for (int r = 0; r < K-1; r++) r_win[r][K-1] <= r_line[r][LineWidthPx-2];
      r_win[K-1][K-1] <= data_i;
      if (r_x == '0 && r_y == '0) begin
        r_wts  <= weights_i;
        r_relu <= relu_en_i;
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < ChannelsOut; ch++) begin
      w_acc[ch] = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          w_acc[ch] = w_acc[ch] + mul(r_wts[(ch*KK + r*K + c)*WeightWidth +: WeightWidth],
                                      r_win[r][c]);
    end
  end

  always_comb begin
    w_data = '0;
    for (int ch = 0; ch < ChannelsOut; ch++)
      w_data[ch*WidthOut +: WidthOut] = requant(w_acc[ch], r_relu);
  end

  // Output stage: data stays combinational off the window, which freezes while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (ready_o) begin
      r_valid <= w_produce;
      r_last  <= w_produce & w_last;
    end
  end

  assign valid_o = r_valid;
  assign last_o  = r_last;
  assign data_o  = w_data;
endmodule

// File: tb/tb_conv2d_mc.sv
// Scoreboard bench for conv2d_mc: a stride-1/shift-0 instance and a stride-2/shift-5
// instance share the input stream; each is tracked by its own golden model.
module tb_conv2d_mc;
  localparam int W = 8, H = 6, K = 3, CO = 4, WW = 3, WI = 8, WO = 8;
  localparam int NW = CO * K * K * WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, valid_i, ready_i, relu;
  logic [WI-1:0] din;
  logic [NW-1:0] wts;
  logic a_ready, a_valid, a_last, b_ready, b_valid, b_last;
  logic [CO*WO-1:0] a_data, b_data;

  conv2d_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(WI), .WeightWidth(WW),
              .KernelWidth(K), .ChannelsOut(CO), .Stride(1), .Shift(0), .WidthOut(WO)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(a_ready), .data_i(din),
    .weights_i(wts), .relu_en_i(relu), .valid_o(a_valid), .ready_i(ready_i),
    .data_o(a_data), .last_o(a_last));

  conv2d_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(WI), .WeightWidth(WW),
              .KernelWidth(K), .ChannelsOut(CO), .Stride(2), .Shift(5), .WidthOut(WO)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(b_ready), .data_i(din),
    .weights_i(wts), .relu_en_i(relu), .valid_o(b_valid), .ready_i(ready_i),
    .data_o(b_data), .last_o(b_last));

  typedef struct {
    logic [CO*WO-1:0] data;
    logic             last;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_chk = 0, n_fail = 0;
  int mx[2], my[2];
  int img[2][H][W];
  logic [NW-1:0] sh_w[2];
  logic sh_r[2];
  int cnt[2], last_idx[2];
  logic [CO*WO-1:0] obs[2];
  bit fa;

  function automatic logic [CO*WO-1:0] golden(input int d, input int x, input int y);
    logic [CO*WO-1:0] res;
    logic signed [WW-1:0] wq;
    logic [31:0] t;
    int acc, s, sh;
    res = '0;
    sh  = (d == 0) ? 0 : 5;
    for (int c = 0; c < CO; c++) begin
      acc = 0;
      for (int r = 0; r < K; r++)
        for (int q = 0; q < K; q++) begin
          wq  = sh_w[d][(c*K*K + r*K + q)*WW +: WW];
          acc = acc + int'(wq) * img[d][y-K+1+r][x-K+1+q];
        end
      s = acc >>> sh;
      if (sh_r[d] && s < 0) s = 0;
      if (s > 2**(WO-1)-1) s = 2**(WO-1)-1;
      if (s < -(2**(WO-1))) s = -(2**(WO-1));
      t = s;
      res[c*WO +: WO] = t[WO-1:0];
    end
    return res;
  endfunction

  function automatic void model_accept(input int d, input int pix);
    exp_t e;
    int st, xl, yl;
    st = (d == 0) ? 1 : 2;
    xl = K - 1 + st * ((W - K) / st);
    yl = K - 1 + st * ((H - K) / st);
    if (mx[d] == 0 && my[d] == 0) begin
      sh_w[d] = wts;
      sh_r[d] = relu;
    end
    img[d][my[d]][mx[d]] = pix;
    if (mx[d] >= K-1 && my[d] >= K-1 && (mx[d]-K+1) % st == 0 && (my[d]-K+1) % st == 0) begin
      e.data = golden(d, mx[d], my[d]);
      e.last = (mx[d] == xl && my[d] == yl);
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    if (mx[d] == W-1) begin
      mx[d] = 0;
      my[d] = (my[d] == H-1) ? 0 : my[d] + 1;
    end else begin
      mx[d] = mx[d] + 1;
    end
  endfunction

  // One clock: score outputs consumed at this edge, log accepted pixels, advance to posedge+1.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (a_valid && ready_i) begin
      n_chk++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a unexpected output data=%h last=%b", a_data, a_last);
      end else begin
        e = qa.pop_front();
        if (a_data !== e.data || a_last !== e.last) begin
          n_fail++;
          $display("FAIL sb_a got data=%h last=%b expected data=%h last=%b", a_data, a_last, e.data, e.last);
        end
      end
      cnt[0]++;
      if (a_last) last_idx[0] = cnt[0];
      obs[0] = a_data;
    end
    if (b_valid && ready_i) begin
      n_chk++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b unexpected output data=%h last=%b", b_data, b_last);
      end else begin
        e = qb.pop_front();
        if (b_data !== e.data || b_last !== e.last) begin
          n_fail++;
          $display("FAIL sb_b got data=%h last=%b expected data=%h last=%b", b_data, b_last, e.data, e.last);
        end
      end
      cnt[1]++;
      if (b_last) last_idx[1] = cnt[1];
      obs[1] = b_data;
    end
    fa = valid_i && a_ready;
    if (valid_i && a_ready) model_accept(0, int'(din));
    if (valid_i && b_ready) model_accept(1, int'(din));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      valid_i = 1'b1;
      din = (mode == 0) ? WI'(1) : (mode == 1) ? WI'(255) : WI'($urandom_range(0, 255));
      do begin
        step();
        g++;
      end while (!fa && g < 50);
      if (!fa) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout pixel %0d not accepted", i);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; sh_w[d] = '0; sh_r[d] = 1'b0;
      cnt[d] = 0; last_idx[d] = 0; obs[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int ea, input int eb);
    n_chk++;
    if (cnt[0] !== ea || last_idx[0] !== ea) begin
      n_fail++;
      $display("FAIL %s_count_a got %0d last_at %0d expected %0d", nm, cnt[0], last_idx[0], ea);
    end
    n_chk++;
    if (cnt[1] !== eb || last_idx[1] !== eb) begin
      n_fail++;
      $display("FAIL %s_count_b got %0d last_at %0d expected %0d", nm, cnt[1], last_idx[1], eb);
    end
    n_chk++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending got %0d/%0d expected 0/0", nm, qa.size(), qb.size());
    end
  endtask

  task automatic rand_weights();
    for (int i = 0; i < CO*K*K; i++) wts[i*WW +: WW] = WW'($urandom);
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (a_valid !== 1'b0 || a_last !== 1'b0 || a_data !== '0 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a got v=%b l=%b d=%h r=%b expected 0 0 0 1", a_valid, a_last, a_data, a_ready);
    end
    n_chk++;
    if (b_valid !== 1'b0 || b_last !== 1'b0 || b_data !== '0 || b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_b got v=%b l=%b d=%h r=%b expected 0 0 0 1", b_valid, b_last, b_data, b_ready);
    end
  endtask

  task automatic test_ones();
    for (int i = 0; i < CO*K*K; i++) wts[i*WW +: WW] = 3'b001;
    relu = 1'b0;
    apply_reset();
    send(W*H, 0);
    drain();
    check_frame("ones", 24, 6);
    n_chk++;
    if (obs[0] !== {CO{8'd9}} || obs[1] !== '0) begin
      n_fail++;
      $display("FAIL ones_value got a=%h b=%h expected a=%h b=0", obs[0], obs[1], {CO{8'd9}});
    end
  endtask

  task automatic test_stride_back_to_back();
    rand_weights();
    relu = 1'b0;
    apply_reset();
    send(2*W*H, 2);
    drain();
    check_frame("stride_b2b", 48, 12);
  endtask

  task automatic test_saturation();
    wts = '0;
    for (int i = 0; i < K*K; i++) begin
      wts[i*WW +: WW]         = 3'b001;
      wts[(K*K + i)*WW +: WW] = 3'b110;
    end
    relu = 1'b0;
    apply_reset();
    send(W*H, 1);
    drain();
    n_chk++;
    if (obs[0][7:0] !== 8'd127 || obs[0][15:8] !== 8'h80) begin
      n_fail++;
      $display("FAIL sat_shift0 got ch0=%h ch1=%h expected 7f 80", obs[0][7:0], obs[0][15:8]);
    end
    n_chk++;
    if (obs[1][7:0] !== 8'd71 || obs[1][15:8] !== 8'h80) begin
      n_fail++;
      $display("FAIL sat_shift5 got ch0=%h ch1=%h expected 47 80", obs[1][7:0], obs[1][15:8]);
    end
    relu = 1'b1;
    send(W*H, 1);
    drain();
    n_chk++;
    if (obs[0][7:0] !== 8'd127 || obs[0][15:8] !== 8'h00 || obs[1][15:8] !== 8'h00) begin
      n_fail++;
      $display("FAIL sat_relu got a0=%h a1=%h b1=%h expected 7f 00 00", obs[0][7:0], obs[0][15:8], obs[1][15:8]);
    end
    relu = 1'b0;
  endtask

  task automatic test_backpressure();
    int i;
    logic [CO*WO-1:0] hd;
    logic hl;
    rand_weights();
    apply_reset();
    i = 0;
    while (i < W*H && a_valid !== 1'b1) begin
      send(1, 2);
      i++;
    end
    n_chk++;
    if (a_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_valid got %b expected 1", a_valid);
    end
    hd = a_data;
    hl = a_last;
    ready_i = 1'b0;
    valid_i = 1'b1;
    din = WI'($urandom_range(0, 255));
    repeat (5) begin
      step();
      n_chk++;
      if (a_ready !== 1'b0 || a_valid !== 1'b1 || a_data !== hd || a_last !== hl) begin
        n_fail++;
        $display("FAIL bp_hold got r=%b v=%b d=%h l=%b expected 0 1 %h %b", a_ready, a_valid, a_data, a_last, hd, hl);
      end
    end
    ready_i = 1'b1;
    send(W*H - i, 2);
    drain();
    n_chk++;
    if (cnt[0] !== 24 || last_idx[0] !== 24 || qa.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count got %0d last_at %0d pending %0d expected 24 24 0", cnt[0], last_idx[0], qa.size());
    end
  endtask

  task automatic test_weight_change();
    rand_weights();
    apply_reset();
    send(20, 2);
    rand_weights();
    relu = 1'b1;
    send(W*H - 20, 2);
    send(W*H, 2);
    drain();
    check_frame("wchange", 48, 12);
    relu = 1'b0;
  endtask

  task automatic test_reset_midframe();
    rand_weights();
    apply_reset();
    send(30, 2);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_valid !== 1'b0 || a_last !== 1'b0 || a_data !== '0) begin
      n_fail++;
      $display("FAIL async_rst_a got v=%b l=%b d=%h expected 0 0 0", a_valid, a_last, a_data);
    end
    n_chk++;
    if (b_valid !== 1'b0 || b_data !== '0) begin
      n_fail++;
      $display("FAIL async_rst_b got v=%b d=%h expected 0 0", b_valid, b_data);
    end
    apply_reset();
    send(W*H, 2);
    drain();
    check_frame("after_rst", 24, 6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    relu = 1'b0;
    din = '0;
    wts = '0;
    test_reset();
    test_ones();
    test_stride_back_to_back();
    test_saturation();
    test_backpressure();
    test_weight_change();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
